// File: rtl/fb_sram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_sram_arbiter_if
// Purpose  : Bus bundle between the framebuffer SRAM arbiter, its two external
//            requesters (R0 rasterizer, R1 host), the clear-control inputs and
//            the GPU-SRAM port.
// Ports    : I_VIDEO_ON          - active video, blocks new SRAM accesses
//            I_REQx/WEx/ADDRx/WDATAx, O_ACKx - requester handshakes (x = 0, 1)
//            O_RDATA             - read data, valid with the O_ACKx of a read
//            I_CLR_START/COLOR, O_CLR_BUSY/DONE - frame-clear control
//            O_GPU_ADDR/DATA/WRITE/READ, I_GPU_DATA - SRAM port
// Modports : slave  - arbiter side
//            master - requester / SRAM-model side
// Revision : 1.0 - initial release
// ============================================================================
interface fb_sram_arbiter_if;
  logic        I_VIDEO_ON;
  logic        I_REQ0;
  logic        I_REQ1;
  logic        I_WE0;
  logic        I_WE1;
  logic [17:0] I_ADDR0;
  logic [17:0] I_ADDR1;
  logic [15:0] I_WDATA0;
  logic [15:0] I_WDATA1;
  logic        O_ACK0;
  logic        O_ACK1;
  logic [15:0] O_RDATA;
  logic        I_CLR_START;
  logic [15:0] I_CLR_COLOR;
  logic        O_CLR_BUSY;
  logic        O_CLR_DONE;
  logic [17:0] O_GPU_ADDR;
  logic [15:0] O_GPU_DATA;
  logic        O_GPU_WRITE;
  logic        O_GPU_READ;
  logic [15:0] I_GPU_DATA;

  modport slave (
    input  I_VIDEO_ON, I_REQ0, I_REQ1, I_WE0, I_WE1, I_ADDR0, I_ADDR1,
           I_WDATA0, I_WDATA1, I_CLR_START, I_CLR_COLOR, I_GPU_DATA,
    output O_ACK0, O_ACK1, O_RDATA, O_CLR_BUSY, O_CLR_DONE,
           O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ
  );

  modport master (
    output I_VIDEO_ON, I_REQ0, I_REQ1, I_WE0, I_WE1, I_ADDR0, I_ADDR1,
           I_WDATA0, I_WDATA1, I_CLR_START, I_CLR_COLOR, I_GPU_DATA,
    input  O_ACK0, O_ACK1, O_RDATA, O_CLR_BUSY, O_CLR_DONE,
           O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ
  );
endinterface
`default_nettype wire

// File: rtl/fb_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_sram_arbiter
// Purpose  : Shares the single 16-bit framebuffer SRAM port between the
//            rasterizer (R0), the host (R1) and an internal frame-clear
//            sequencer (CLR). Accesses are issued only during blanking, with
//            round-robin priority R0 -> R1 -> CLR -> R0.
// Ports    : I_CLK   - clock
//            I_RST_N - asynchronous active-low reset
//            bus     - fb_sram_arbiter_if.slave (requesters, clear, SRAM port)
// Params   : FB_WORDS - words written by a frame clear (must be <= 2**18)
// Revision : 1.0 - initial release
// ============================================================================
module fb_sram_arbiter #(
  parameter int unsigned FB_WORDS = 256000
) (
  input wire               I_CLK,
  input wire               I_RST_N,
  fb_sram_arbiter_if.slave bus
);

  localparam logic [17:0] c_last_addr = 18'(FB_WORDS - 1);

  // A read occupies the port for two cycles after the grant: the strobe
  // cycle (RD_ISSUE) and the SRAM data cycle (RD_WAIT).
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_R0  = 2'd0,
    SRC_R1  = 2'd1,
    SRC_CLR = 2'd2
  } src_t;

  state_t      r_state,      w_state_nxt;
  src_t        r_last,       w_last_nxt;
  logic        r_rd_owner,   w_rd_owner_nxt;   // 0 = R0, 1 = R1
  logic [17:0] r_clr_cnt,    w_clr_cnt_nxt;
  logic [15:0] r_clr_color,  w_clr_color_nxt;
  logic        r_clr_busy,   w_clr_busy_nxt;
  logic        r_clr_done,   w_clr_done_nxt;
  logic [17:0] r_gpu_addr,   w_gpu_addr_nxt;
  logic [15:0] r_gpu_data,   w_gpu_data_nxt;
  logic        r_gpu_write,  w_gpu_write_nxt;
  logic        r_gpu_read,   w_gpu_read_nxt;
  logic        r_ack0,       w_ack0_nxt;
  logic        r_ack1,       w_ack1_nxt;
  logic [15:0] r_rdata,      w_rdata_nxt;

  logic [2:0]  w_elig;
  src_t        w_win;
  logic        w_grant;
  logic        w_sel_we;
  logic [17:0] w_sel_addr;
  logic [15:0] w_sel_wdata;

  // A requester whose ACK is high this cycle still shows its old REQ, so it
  // is masked to avoid granting the same transaction twice.
  assign w_elig = {r_clr_busy, bus.I_REQ1 & ~r_ack1, bus.I_REQ0 & ~r_ack0};

  // First eligible source after the last winner. When nothing is eligible
  // the result is unused because w_grant is low.
  always_comb begin
    w_win = SRC_R0;
    unique case (r_last)
      SRC_R0: begin
        if (w_elig[1])      w_win = SRC_R1;
        else if (w_elig[2]) w_win = SRC_CLR;
        else                w_win = SRC_R0;
      end
      SRC_R1: begin
        if (w_elig[2])      w_win = SRC_CLR;
        else if (w_elig[0]) w_win = SRC_R0;
        else                w_win = SRC_R1;
      end
      default: begin
        if (w_elig[0])      w_win = SRC_R0;
        else if (w_elig[1]) w_win = SRC_R1;
        else                w_win = SRC_CLR;
      end
    endcase
  end

  assign w_grant     = (r_state == ST_IDLE) & ~bus.I_VIDEO_ON & (|w_elig);
  assign w_sel_we    = (w_win == SRC_R1) ? bus.I_WE1    : bus.I_WE0;
  assign w_sel_addr  = (w_win == SRC_R1) ? bus.I_ADDR1  : bus.I_ADDR0;
  assign w_sel_wdata = (w_win == SRC_R1) ? bus.I_WDATA1 : bus.I_WDATA0;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_rd_owner_nxt  = r_rd_owner;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_clr_color_nxt = r_clr_color;
    w_clr_busy_nxt  = r_clr_busy;
    w_clr_done_nxt  = 1'b0;
    w_gpu_addr_nxt  = r_gpu_addr;
    w_gpu_data_nxt  = r_gpu_data;
    w_gpu_write_nxt = 1'b0;
    w_gpu_read_nxt  = 1'b0;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_rdata_nxt     = r_rdata;

    unique case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_last_nxt = w_win;
          if (w_win == SRC_CLR) begin
            w_gpu_write_nxt = 1'b1;
            w_gpu_addr_nxt  = r_clr_cnt;
            w_gpu_data_nxt  = r_clr_color;
            if (r_clr_cnt == c_last_addr) begin
              w_clr_busy_nxt = 1'b0;
              w_clr_done_nxt = 1'b1;
            end else begin
              w_clr_cnt_nxt = r_clr_cnt + 18'd1;
            end
          end else if (w_sel_we) begin
            w_gpu_write_nxt = 1'b1;
            w_gpu_addr_nxt  = w_sel_addr;
            w_gpu_data_nxt  = w_sel_wdata;
            w_ack0_nxt      = (w_win == SRC_R0);
            w_ack1_nxt      = (w_win == SRC_R1);
          end else begin
            w_gpu_read_nxt = 1'b1;
            w_gpu_addr_nxt = w_sel_addr;
            w_rd_owner_nxt = (w_win == SRC_R1);
            w_state_nxt    = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_rdata_nxt = bus.I_GPU_DATA;
        w_ack0_nxt  = ~r_rd_owner;
        w_ack1_nxt  = r_rd_owner;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // CLR is only eligible while busy, so a start never collides with a
    // clear grant in the same cycle.
    if (bus.I_CLR_START && !r_clr_busy) begin
      w_clr_color_nxt = bus.I_CLR_COLOR;
      w_clr_cnt_nxt   = 18'd0;
      w_clr_busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state     <= ST_IDLE;
      r_last      <= SRC_CLR;
      r_rd_owner  <= 1'b0;
      r_clr_cnt   <= 18'd0;
      r_clr_color <= 16'd0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_gpu_addr  <= 18'd0;
      r_gpu_data  <= 16'd0;
      r_gpu_write <= 1'b0;
      r_gpu_read  <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata     <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_rd_owner  <= w_rd_owner_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_clr_color <= w_clr_color_nxt;
      r_clr_busy  <= w_clr_busy_nxt;
      r_clr_done  <= w_clr_done_nxt;
      r_gpu_addr  <= w_gpu_addr_nxt;
      r_gpu_data  <= w_gpu_data_nxt;
      r_gpu_write <= w_gpu_write_nxt;
      r_gpu_read  <= w_gpu_read_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign bus.O_ACK0      = r_ack0;
  assign bus.O_ACK1      = r_ack1;
  assign bus.O_RDATA     = r_rdata;
  assign bus.O_CLR_BUSY  = r_clr_busy;
  assign bus.O_CLR_DONE  = r_clr_done;
  assign bus.O_GPU_ADDR  = r_gpu_addr;
  assign bus.O_GPU_DATA  = r_gpu_data;
  assign bus.O_GPU_WRITE = r_gpu_write;
  assign bus.O_GPU_READ  = r_gpu_read;

endmodule
`default_nettype wire

// File: tb/tb_fb_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_sram_arbiter
// Purpose  : Self-checking bench for fb_sram_arbiter (FB_WORDS = 8): vector
//            table, directed multi-cycle sequences and randomized traffic
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_sram_arbiter;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_sram_arbiter_if bus();
  fb_sram_arbiter #(.FB_WORDS(FB)) dut (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- SRAM model (one-cycle read latency) --------------------
  logic [15:0] sram [256];
  bit   [255:0] wr_valid;
  logic [17:0] log_addr [$];
  logic [15:0] log_data [$];
  int n_strobe = 0;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'd5) ? 16'h1234 : ({a, ~a} ^ 16'h3C5A);
  endfunction

  always @(posedge clk) begin
    if (bus.O_GPU_WRITE) begin
      sram[bus.O_GPU_ADDR[7:0]] <= bus.O_GPU_DATA;
      wr_valid[bus.O_GPU_ADDR[7:0]] <= 1'b1;
      log_addr.push_back(bus.O_GPU_ADDR);
      log_data.push_back(bus.O_GPU_DATA);
      n_strobe++;
    end
    if (bus.O_GPU_READ) begin
      bus.I_GPU_DATA <= wr_valid[bus.O_GPU_ADDR[7:0]] ? sram[bus.O_GPU_ADDR[7:0]]
                                                      : init_val(bus.O_GPU_ADDR[7:0]);
      n_strobe++;
    end
  end

  // ---------------- Reference model ----------------------------------------
  // Sources 0 = R0, 1 = R1, 2 = CLR. m_rd counts cycles of an open read.
  logic [15:0] mmem [256];
  int          m_last, m_rd, m_rdown;
  bit          m_busy;
  logic [17:0] m_cnt, m_raddr;
  logic [15:0] m_color;
  logic        e_write, e_read, e_ack0, e_ack1, e_busy, e_done;
  logic [17:0] e_addr;
  logic [15:0] e_data, e_rdata;

  task automatic model_reset();
    m_last = 2; m_rd = 0; m_rdown = 0; m_busy = 0; m_cnt = 0; m_raddr = 0; m_color = 0;
    e_write = 0; e_read = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_done = 0;
    e_addr = 0; e_data = 0; e_rdata = 0;
  endtask

  task automatic model_step();
    logic [2:0]  el;
    int          w;
    bit          old_busy;
    logic        we;
    logic [17:0] a;
    logic [15:0] d;
    old_busy = m_busy;
    el = {m_busy, bus.I_REQ1 & ~e_ack1, bus.I_REQ0 & ~e_ack0};
    e_write = 0; e_read = 0; e_ack0 = 0; e_ack1 = 0; e_done = 0;
    if (m_rd == 1) begin
      m_rd = 2;
    end else if (m_rd == 2) begin
      e_rdata = mmem[m_raddr[7:0]];
      if (m_rdown == 0) e_ack0 = 1; else e_ack1 = 1;
      m_rd = 0;
    end else if (!bus.I_VIDEO_ON) begin
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && el[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (w >= 0) begin
        m_last = w;
        if (w == 2) begin
          e_write = 1; e_addr = m_cnt; e_data = m_color;
          mmem[m_cnt[7:0]] = m_color;
          if (int'(m_cnt) == FB - 1) begin m_busy = 0; e_done = 1; end
          else m_cnt = m_cnt + 18'd1;
        end else begin
          we = (w == 0) ? bus.I_WE0    : bus.I_WE1;
          a  = (w == 0) ? bus.I_ADDR0  : bus.I_ADDR1;
          d  = (w == 0) ? bus.I_WDATA0 : bus.I_WDATA1;
          e_addr = a;
          if (we) begin
            e_write = 1; e_data = d; mmem[a[7:0]] = d;
            if (w == 0) e_ack0 = 1; else e_ack1 = 1;
          end else begin
            e_read = 1; m_rd = 1; m_rdown = w; m_raddr = a;
          end
        end
      end
    end
    if (bus.I_CLR_START && !old_busy) begin
      m_busy = 1; m_cnt = 0; m_color = bus.I_CLR_COLOR;
    end
    e_busy = m_busy;
  endtask

  // ---------------- Checking helpers ---------------------------------------
  function automatic logic [55:0] act_vec();
    return {bus.O_GPU_WRITE, bus.O_GPU_READ, bus.O_GPU_ADDR, bus.O_GPU_DATA,
            bus.O_ACK0, bus.O_ACK1, bus.O_RDATA, bus.O_CLR_BUSY, bus.O_CLR_DONE};
  endfunction

  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", act_vec(), {e_write, e_read, e_addr, e_data, e_ack0, e_ack1,
                             e_rdata, e_busy, e_done});
  endtask

  task automatic idle_inputs();
    bus.I_VIDEO_ON = 0; bus.I_REQ0 = 0; bus.I_REQ1 = 0; bus.I_WE0 = 0; bus.I_WE1 = 0;
    bus.I_ADDR0 = 0; bus.I_ADDR1 = 0; bus.I_WDATA0 = 0; bus.I_WDATA1 = 0;
    bus.I_CLR_START = 0; bus.I_CLR_COLOR = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act_vec(), 56'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- Vector table -------------------------------------------
  typedef struct {
    logic        req0, we0; logic [17:0] a0; logic [15:0] d0;
    logic        req1, we1; logic [17:0] a1; logic [15:0] d1;
    logic        video;
    logic        x_wr, x_rd; logic [17:0] x_addr; logic [15:0] x_data;
    logic        x_ack0, x_ack1; logic [15:0] x_rdata;
  } vec_t;

  vec_t tbl [13];

  initial begin : main
    int base, dones, i0, i1, acks, busy_cnt;
    logic [17:0] ea; logic [15:0] ed;

    for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
    idle_inputs();
    model_reset();

    tbl[0]  = '{1'b1,1'b1,18'h100,16'hABCD, 1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b1,1'b0,18'h100,16'hABCD,1'b1,1'b0,16'h0000};
    tbl[1]  = '{1'b0,1'b0,18'h0,16'h0,     1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b0,1'b0,18'h100,16'hABCD,1'b0,1'b0,16'h0000};
    tbl[2]  = '{1'b0,1'b0,18'h0,16'h0,     1'b1,1'b0,18'h5,16'h0, 1'b0, 1'b0,1'b1,18'h005,16'hABCD,1'b0,1'b0,16'h0000};
    tbl[3]  = '{1'b0,1'b0,18'h0,16'h0,     1'b1,1'b0,18'h5,16'h0, 1'b0, 1'b0,1'b0,18'h005,16'hABCD,1'b0,1'b0,16'h0000};
    tbl[4]  = '{1'b0,1'b0,18'h0,16'h0,     1'b1,1'b0,18'h5,16'h0, 1'b0, 1'b0,1'b0,18'h005,16'hABCD,1'b0,1'b1,16'h1234};
    tbl[5]  = '{1'b0,1'b0,18'h0,16'h0,     1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b0,1'b0,18'h005,16'hABCD,1'b0,1'b0,16'h1234};
    tbl[6]  = '{1'b1,1'b1,18'h7,16'h1111,  1'b0,1'b0,18'h0,16'h0, 1'b1, 1'b0,1'b0,18'h005,16'hABCD,1'b0,1'b0,16'h1234};
    tbl[7]  = '{1'b1,1'b1,18'h7,16'h1111,  1'b0,1'b0,18'h0,16'h0, 1'b1, 1'b0,1'b0,18'h005,16'hABCD,1'b0,1'b0,16'h1234};
    tbl[8]  = '{1'b1,1'b1,18'h7,16'h1111,  1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b1,1'b0,18'h007,16'h1111,1'b1,1'b0,16'h1234};
    tbl[9]  = '{1'b1,1'b1,18'h20,16'h2222, 1'b1,1'b1,18'h21,16'h3333, 1'b0, 1'b1,1'b0,18'h021,16'h3333,1'b0,1'b1,16'h1234};
    tbl[10] = '{1'b1,1'b1,18'h20,16'h2222, 1'b1,1'b1,18'h21,16'h3333, 1'b0, 1'b1,1'b0,18'h020,16'h2222,1'b1,1'b0,16'h1234};
    tbl[11] = '{1'b1,1'b1,18'h20,16'h2222, 1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b0,1'b0,18'h020,16'h2222,1'b0,1'b0,16'h1234};
    tbl[12] = '{1'b0,1'b0,18'h0,16'h0,     1'b0,1'b0,18'h0,16'h0, 1'b0, 1'b0,1'b0,18'h020,16'h2222,1'b0,1'b0,16'h1234};

    do_reset();

    // ---- table: single write, read latency, blanking, contention, mask ----
    for (int i = 0; i < 13; i++) begin
      bus.I_REQ0 = tbl[i].req0; bus.I_WE0 = tbl[i].we0; bus.I_ADDR0 = tbl[i].a0; bus.I_WDATA0 = tbl[i].d0;
      bus.I_REQ1 = tbl[i].req1; bus.I_WE1 = tbl[i].we1; bus.I_ADDR1 = tbl[i].a1; bus.I_WDATA1 = tbl[i].d1;
      bus.I_VIDEO_ON = tbl[i].video;
      tick();
      chk($sformatf("vec%0d", i),
          {2'b00, bus.O_GPU_WRITE, bus.O_GPU_READ, bus.O_GPU_ADDR, bus.O_GPU_DATA,
           bus.O_ACK0, bus.O_ACK1, bus.O_RDATA},
          {2'b00, tbl[i].x_wr, tbl[i].x_rd, tbl[i].x_addr, tbl[i].x_data,
           tbl[i].x_ack0, tbl[i].x_ack1, tbl[i].x_rdata});
    end

    // ---- blanking gate: 50 cycles of active video with R0 pending ----
    base = n_strobe;
    bus.I_VIDEO_ON = 1; bus.I_REQ0 = 1; bus.I_WE0 = 1; bus.I_ADDR0 = 18'h9; bus.I_WDATA0 = 16'h5555;
    repeat (50) tick();
    chk("blank_strobes", 56'(n_strobe - base), 56'd0);
    bus.I_VIDEO_ON = 0;
    tick();
    chk("blank_ack", {54'd0, bus.O_ACK0, bus.O_GPU_WRITE}, {54'd0, 1'b1, 1'b1});
    bus.I_REQ0 = 0;
    tick();

    // ---- round robin: R0 and R1 four writes each, clear of 8 words ----
    do_reset();
    base = log_addr.size();
    bus.I_CLR_START = 1; bus.I_CLR_COLOR = 16'hC0DE;
    tick();
    bus.I_CLR_START = 0; bus.I_CLR_COLOR = 16'h0;
    i0 = 0; i1 = 0; dones = 0;
    bus.I_REQ0 = 1; bus.I_WE0 = 1; bus.I_ADDR0 = 18'h40; bus.I_WDATA0 = 16'hA000;
    bus.I_REQ1 = 1; bus.I_WE1 = 1; bus.I_ADDR1 = 18'h80; bus.I_WDATA1 = 16'hB000;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.O_CLR_DONE) dones++;
      if (bus.O_ACK0) begin
        i0++;
        if (i0 < 4) begin bus.I_ADDR0 = 18'(64 + i0); bus.I_WDATA0 = 16'(16'hA000 + i0); end
        else bus.I_REQ0 = 0;
      end
      if (bus.O_ACK1) begin
        i1++;
        if (i1 < 4) begin bus.I_ADDR1 = 18'(128 + i1); bus.I_WDATA1 = 16'(16'hB000 + i1); end
        else bus.I_REQ1 = 0;
      end
    end
    chk("rr_count", 56'(log_addr.size() - base), 56'd16);
    chk("rr_done", 56'(dones), 56'd1);
    for (int k = 0; k < 16; k++) begin
      if (k < 12) begin
        case (k % 3)
          0:       begin ea = 18'(64 + k / 3);  ed = 16'(16'hA000 + k / 3); end
          1:       begin ea = 18'(128 + k / 3); ed = 16'(16'hB000 + k / 3); end
          default: begin ea = 18'(k / 3);       ed = 16'hC0DE; end
        endcase
      end else begin
        ea = 18'(k - 8); ed = 16'hC0DE;
      end
      if (base + k < log_addr.size())
        chk($sformatf("rr_wr%0d", k), {22'd0, log_addr[base + k], log_data[base + k]}, {22'd0, ea, ed});
      else
        chk($sformatf("rr_wr%0d", k), 56'hFFFFFFFFFFFFFF, {22'd0, ea, ed});
    end

    // ---- full clear of color 0, second START mid-clear ignored ----
    base = log_addr.size();
    dones = 0; busy_cnt = 0;
    bus.I_CLR_START = 1; bus.I_CLR_COLOR = 16'h0000;
    tick();
    if (bus.O_CLR_BUSY) busy_cnt++;
    bus.I_CLR_START = 0;
    for (int c = 0; c < 20; c++) begin
      bus.I_CLR_START = (c == 3); bus.I_CLR_COLOR = (c == 3) ? 16'hFFFF : 16'h0000;
      tick();
      if (bus.O_CLR_BUSY) busy_cnt++;
      if (bus.O_CLR_DONE) dones++;
    end
    bus.I_CLR_START = 0; bus.I_CLR_COLOR = 0;
    chk("clr_count", 56'(log_addr.size() - base), 56'(FB));
    chk("clr_done", 56'(dones), 56'd1);
    chk("clr_busy_cycles", 56'(busy_cnt), 56'(FB));
    for (int k = 0; k < FB; k++)
      if (base + k < log_addr.size())
        chk($sformatf("clr_wr%0d", k), {22'd0, log_addr[base + k], log_data[base + k]}, {22'd0, 18'(k), 16'h0000});

    // ---- reset asserted while a read is in RD_WAIT ----
    bus.I_REQ1 = 1; bus.I_WE1 = 0; bus.I_ADDR1 = 18'h5;
    tick();
    tick();
    #2;
    rst_n = 0;
    bus.I_REQ1 = 0;
    #1;
    chk("rst_midread", act_vec(), 56'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    repeat (5) begin tick(); if (bus.O_ACK0 || bus.O_ACK1) acks++; end
    chk("rst_no_ack", 56'(acks), 56'd0);
    bus.I_REQ0 = 1; bus.I_WE0 = 1; bus.I_ADDR0 = 18'h33; bus.I_WDATA0 = 16'h7777;
    tick();
    chk("rst_then_write", {20'd0, bus.O_GPU_WRITE, bus.O_ACK0, bus.O_GPU_ADDR, bus.O_GPU_DATA},
        {20'd0, 1'b1, 1'b1, 18'h33, 16'h7777});
    bus.I_REQ0 = 0;
    tick();

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) bus.I_VIDEO_ON = ~bus.I_VIDEO_ON;
      bus.I_CLR_START = ($urandom_range(0, 39) == 0);
      bus.I_CLR_COLOR = 16'($urandom);
      tick();
      if (bus.O_ACK0 || !bus.I_REQ0) begin
        bus.I_REQ0 = ($urandom_range(0, 2) != 0);
        bus.I_WE0 = 1'($urandom_range(0, 1));
        bus.I_ADDR0 = 18'($urandom_range(0, 63));
        bus.I_WDATA0 = 16'($urandom);
      end
      if (bus.O_ACK1 || !bus.I_REQ1) begin
        bus.I_REQ1 = ($urandom_range(0, 2) != 0);
        bus.I_WE1 = 1'($urandom_range(0, 1));
        bus.I_ADDR1 = 18'($urandom_range(0, 63));
        bus.I_WDATA1 = 16'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
